clip_edge_sequencer: RTL
========================

// Module: clip_edge_sequencer
// PURPOSE
//  Initiator side of the clip arithmetic interface: walks one polygon edge (v1->v2) against one clip plane.
//  Classifies both vertices, drives calc_t_num/den and interp_v1/v2/t to the external combinational helper.
//  Emits 0, 1 or 2 output vertices per edge (Sutherland-Hodgman rule) on a valid/ready stream to the assembler.
// PARAMETERS
//  NUM_ATTR   4   extra 32-bit attributes after x,y,z,w; vertex = (4+NUM_ATTR) words, word0=x..word3=w
//  VW         (4+NUM_ATTR)*32   derived flat vertex width (localparam)
// PORTS
//  clk_i           in   1    clock
//  rst_ni          in   1    async active-low reset
//  in_valid_i      in   1    edge request valid
//  in_ready_o      out  1    edge request accepted when valid&ready
//  in_plane_i      in   3    0:+x(w-x) 1:-x(w+x) 2:+y 3:-y 4:+z 5:-z; 6,7 reserved
//  in_v1_i         in   VW   edge start vertex, signed Q.8 words
//  in_v2_i         in   VW   edge end vertex
//  out_valid_o     out  1    output vertex valid
//  out_ready_i     in   1    downstream accepts
//  out_vtx_o       out  VW   output vertex
//  out_last_o      out  1    last vertex emitted for this edge
//  out_none_o      out  1    pulse 1 cycle: edge emitted nothing (both out)
//  calc_t_num_o/calc_t_den_o  out 32 each  to helper; calc_t_result_i in 32 (t, Q0.8, 0..255)
//  interp_v1_o/interp_v2_o/interp_t_o  out 32 each; interp_result_i  in 32
// BEHAVIOUR
//  Reset: state IDLE; out_valid_o=0, out_vtx_o=0, out_last_o=0, out_none_o=0, all helper drive ports 0; in_ready_o=(state==IDLE).
//  States: IDLE -> DIST -> {CALC_T -> INTERP -> EMIT_I [-> EMIT_V2]} | EMIT_V2 | IDLE.
//  IDLE: on in_valid&in_ready latch plane, v1, v2.
//  DIST (1 cyc): d = w - c for even plane, w + c for odd (c = x/y/z); 32-bit wrap. inside = (d >= 0).
//   in,in -> EMIT_V2 (last=1). out,out -> pulse out_none_o, IDLE. in,out or out,in -> CALC_T.
//  CALC_T (1 cyc): num=d1, den=d1-d2 (never 0 on crossing); latch t = calc_t_result_i[7:0].
//   d2==0 on out->in gives num==den -> t=255 (saturated); accepted, not corrected.
//  INTERP: counter k=0..3+NUM_ATTR, one word/cycle: interp_v1=v1[k], v2=v2[k], t; latch result into word k. 4+NUM_ATTR cycles.
//  EMIT_I: out_valid=1, vtx=intersection; last=1 if in->out, 0 if out->in. Hold data stable until ready.
//   On handshake: in->out -> IDLE; out->in -> EMIT_V2.
//  EMIT_V2: vtx=latched v2, last=1; on handshake -> IDLE.
//  Latency accept->first out_valid: in,in 2 cycles; crossing 3+(4+NUM_ATTR) cycles. No edge overlap: one edge in flight.
//  Reserved plane 6/7: treated as both-in (pass v2). Async reset mid-edge: edge discarded, no partial output.
// CONFIGURATION
//  CLIP_PERF_CNT_EN defined: adds outputs perf_edges_o, perf_emitted_o, perf_dropped_o (32 each, reset 0, wrap).
//   edges++ per accepted edge; emitted++ per output handshake; dropped++ per out_none pulse.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  clip_pkg: plane_e enum, FRAC_BITS=8, comp index localparams (X=0,Y=1,Z=2,W=3), state enum.
//  Sub-module clip_plane_dist: combinational plane select + d1/d2 + inside flags, instanced once.
//  Helper stays outside; this block only drives/samples its ports.
// TESTING (bench instances the helper, NUM_ATTR=4)
//  plane0, v1(x=0,w=256) v2(x=512,w=256) -> num=256 den=512 t=128; one vtx x=256,w=256, last=1.
//  plane0, v1(x=512,w=256) v2(x=0,w=256) -> t=128, vtx x=256 last=0, then v2 x=0 last=1.
//  plane1, both x=0,w=256 -> single v2 after 2 cycles, helper ports stay 0.
//  plane2, v1 y=600,v2 y=700,w=256 -> out_none_o pulse, no out_valid, back to IDLE.
//  out_ready_i held 0 for 10 cycles in EMIT_I -> out_vtx_o stable, in_ready_o=0 throughout.
//  rst_ni low during INTERP -> out_valid 0 immediately; next edge produces correct results.

Source files
------------

// File: rtl/clip_pkg.sv
// clip_pkg: shared types and constants for the clip edge sequencer.
//   plane_e   - clip plane selector (6 real planes, 2 reserved codes)
//   state_e   - edge sequencer FSM states
//   FRAC_BITS - fractional bits of vertex words and of the t factor
//   COMP_*    - word index of x/y/z/w inside a vertex
package clip_pkg;

  localparam int WORD_W    = 32;
  localparam int FRAC_BITS = 8;

  localparam logic [1:0] COMP_X = 2'd0;
  localparam logic [1:0] COMP_Y = 2'd1;
  localparam logic [1:0] COMP_Z = 2'd2;
  localparam logic [1:0] COMP_W = 2'd3;

  typedef enum logic [2:0] {
    PLANE_PX   = 3'd0,  // w - x
    PLANE_NX   = 3'd1,  // w + x
    PLANE_PY   = 3'd2,
    PLANE_NY   = 3'd3,
    PLANE_PZ   = 3'd4,
    PLANE_NZ   = 3'd5,
    PLANE_RSV6 = 3'd6,
    PLANE_RSV7 = 3'd7
  } plane_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DIST    = 3'd1,
    ST_CALC_T  = 3'd2,
    ST_INTERP  = 3'd3,
    ST_EMIT_I  = 3'd4,
    ST_EMIT_V2 = 3'd5
  } state_e;

  // Planes come in +/- pairs sharing one component: code>>1 selects x/y/z.
  function automatic logic [1:0] plane_comp(input plane_e p);
    return p[2:1];
  endfunction

  function automatic logic plane_reserved(input plane_e p);
    return (p == PLANE_RSV6) || (p == PLANE_RSV7);
  endfunction

endpackage

// File: rtl/clip_plane_dist.sv
// clip_plane_dist: combinational signed distance of both edge vertices to
// the selected clip plane, plus inside flags.
//   plane_i  - plane code (clip_pkg::plane_e encoding)
//   v1_i/v2_i- vertices, one 32-bit signed Q.8 word per entry (x,y,z,w,attrs)
//   d1_o/d2_o- w - c (even plane) or w + c (odd plane), 32-bit wrap
//   in1_o/in2_o - vertex inside (d >= 0); reserved planes report both inside
module clip_plane_dist
  import clip_pkg::*;
#(
  parameter int NUM_ATTR = 4
) (
  input  logic [2:0]                     plane_i,
  input  logic [4+NUM_ATTR-1:0][31:0]    v1_i,
  input  logic [4+NUM_ATTR-1:0][31:0]    v2_i,
  output logic [31:0]                    d1_o,
  output logic [31:0]                    d2_o,
  output logic                           in1_o,
  output logic                           in2_o
);

  localparam int NW = 4 + NUM_ATTR;
  localparam int KW = $clog2(NW);

  plane_e        plane;
  logic [KW-1:0] c_idx;
  logic [KW-1:0] w_idx;

  always_comb begin
    plane = plane_e'(plane_i);
    c_idx = KW'(plane_comp(plane));
    w_idx = KW'(COMP_W);
    d1_o  = '0;
    d2_o  = '0;
    in1_o = 1'b1;
    in2_o = 1'b1;
    if (!plane_reserved(plane)) begin
      if (plane_i[0]) begin
        d1_o = v1_i[w_idx] + v1_i[c_idx];
        d2_o = v2_i[w_idx] + v2_i[c_idx];
      end else begin
        d1_o = v1_i[w_idx] - v1_i[c_idx];
        d2_o = v2_i[w_idx] - v2_i[c_idx];
      end
      in1_o = ~d1_o[31];
      in2_o = ~d2_o[31];
    end
  end

endmodule

// File: rtl/clip_edge_sequencer.sv
// clip_edge_sequencer: clips one polygon edge (v1->v2) against one plane
// using an external combinational helper for t and per-word interpolation,
// and emits 0, 1 or 2 vertices (Sutherland-Hodgman) downstream.
// Ports:
//   clk_i, rst_ni               - clock, async active-low reset
//   in_valid_i/in_ready_o       - edge request stream (plane, v1, v2)
//   out_valid_o/out_ready_i     - vertex stream (out_vtx_o, out_last_o)
//   out_none_o                  - 1-cycle pulse: edge fully outside
//   calc_t_num_o/den_o, calc_t_result_i        - t = num/den helper
//   interp_v1_o/v2_o/t_o, interp_result_i      - word interpolation helper
//   dbg_state_o                 - current FSM state
// Optional build macro CLIP_PERF_CNT_EN adds perf_edges_o, perf_emitted_o,
// perf_dropped_o (32-bit wrapping event counters).
//
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both high. A producer holding valid keeps its payload stable
// until that edge; ready may toggle freely.
module clip_edge_sequencer
  import clip_pkg::*;
#(
  parameter int NUM_ATTR = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [2:0]                    in_plane_i,
  input  logic [(4+NUM_ATTR)*32-1:0]    in_v1_i,
  input  logic [(4+NUM_ATTR)*32-1:0]    in_v2_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [(4+NUM_ATTR)*32-1:0]    out_vtx_o,
  output logic                          out_last_o,
  output logic                          out_none_o,
  output logic [31:0]                   calc_t_num_o,
  output logic [31:0]                   calc_t_den_o,
  input  logic [31:0]                   calc_t_result_i,
  output logic [31:0]                   interp_v1_o,
  output logic [31:0]                   interp_v2_o,
  output logic [31:0]                   interp_t_o,
  input  logic [31:0]                   interp_result_i,
  output state_e                        dbg_state_o
`ifdef CLIP_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_edges_o,
  output logic [31:0]                   perf_emitted_o,
  output logic [31:0]                   perf_dropped_o
`endif
);

  localparam int NW = 4 + NUM_ATTR;
  localparam int VW = NW * 32;
  localparam int KW = $clog2(NW);
  localparam logic [KW-1:0] K_LAST = KW'(NW - 1);

  state_e                state_q;
  logic [2:0]            plane_q;
  logic [NW-1:0][31:0]   v1_q;
  logic [NW-1:0][31:0]   v2_q;
  logic                  in_to_out_q;  // v1 inside, v2 outside
  logic [KW-1:0]         k_q;
  logic [KW-1:0]         k_d;
  logic                  out_valid_q;
  logic [NW-1:0][31:0]   out_vtx_q;
  logic                  out_last_q;
  logic                  out_none_q;
  logic [31:0]           calc_num_q;
  logic [31:0]           calc_den_q;
  logic [31:0]           interp_v1_q;
  logic [31:0]           interp_v2_q;
  logic [31:0]           interp_t_q;

  logic [31:0]           d1;
  logic [31:0]           d2;
  logic                  in1;
  logic                  in2;

  // t is Q0.8; the helper's upper result bits carry nothing we use.
  logic                  unused_calc_hi;
  assign unused_calc_hi = ^calc_t_result_i[31:8];

  clip_plane_dist #(.NUM_ATTR(NUM_ATTR)) u_dist (
    .plane_i (plane_q),
    .v1_i    (v1_q),
    .v2_i    (v2_q),
    .d1_o    (d1),
    .d2_o    (d2),
    .in1_o   (in1),
    .in2_o   (in2)
  );

  assign k_d = k_q + KW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      plane_q     <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      in_to_out_q <= 1'b0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_vtx_q   <= '0;
      out_last_q  <= 1'b0;
      out_none_q  <= 1'b0;
      calc_num_q  <= '0;
      calc_den_q  <= '0;
      interp_v1_q <= '0;
      interp_v2_q <= '0;
      interp_t_q  <= '0;
    end else begin
      out_none_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            plane_q <= in_plane_i;
            v1_q    <= in_v1_i;
            v2_q    <= in_v2_i;
            state_q <= ST_DIST;
          end
        end
        ST_DIST: begin
          in_to_out_q <= in1;
          if (in1 && in2) begin
            out_vtx_q   <= v2_q;
            out_last_q  <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= ST_EMIT_V2;
          end else if (!in1 && !in2) begin
            out_none_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            // Signs differ on a crossing, so d1 - d2 cannot be zero.
            calc_num_q <= d1;
            calc_den_q <= d1 - d2;
            state_q    <= ST_CALC_T;
          end
        end
        ST_CALC_T: begin
          // The helper result is sampled here; the t drive and word 0 of
          // the interpolation are presented from the next cycle on.
          calc_num_q  <= '0;
          calc_den_q  <= '0;
          interp_v1_q <= v1_q[0];
          interp_v2_q <= v2_q[0];
          interp_t_q  <= {24'd0, calc_t_result_i[7:0]};
          k_q         <= '0;
          state_q     <= ST_INTERP;
        end
        ST_INTERP: begin
          // Intersection words are built directly in the output register;
          // out_valid is low so the partial contents are never visible.
          out_vtx_q[k_q] <= interp_result_i;
          if (k_q == K_LAST) begin
            interp_v1_q <= '0;
            interp_v2_q <= '0;
            interp_t_q  <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= in_to_out_q;
            state_q     <= ST_EMIT_I;
          end else begin
            k_q         <= k_d;
            interp_v1_q <= v1_q[k_d];
            interp_v2_q <= v2_q[k_d];
          end
        end
        ST_EMIT_I: begin
          if (out_ready_i) begin
            if (in_to_out_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= ST_IDLE;
            end else begin
              out_vtx_q  <= v2_q;
              out_last_q <= 1'b1;
              state_q    <= ST_EMIT_V2;
            end
          end
        end
        ST_EMIT_V2: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o   = (state_q == ST_IDLE);
  assign out_valid_o  = out_valid_q;
  assign out_vtx_o    = VW'(out_vtx_q);
  assign out_last_o   = out_last_q;
  assign out_none_o   = out_none_q;
  assign calc_t_num_o = calc_num_q;
  assign calc_t_den_o = calc_den_q;
  assign interp_v1_o  = interp_v1_q;
  assign interp_v2_o  = interp_v2_q;
  assign interp_t_o   = interp_t_q;
  assign dbg_state_o  = state_q;

`ifdef CLIP_PERF_CNT_EN
  logic [31:0] perf_edges_q;
  logic [31:0] perf_emitted_q;
  logic [31:0] perf_dropped_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_edges_q   <= '0;
      perf_emitted_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      if (in_valid_i && in_ready_o) perf_edges_q <= perf_edges_q + 32'd1;
      if (out_valid_q && out_ready_i) perf_emitted_q <= perf_emitted_q + 32'd1;
      if (out_none_q) perf_dropped_q <= perf_dropped_q + 32'd1;
    end
  end

  assign perf_edges_o   = perf_edges_q;
  assign perf_emitted_o = perf_emitted_q;
  assign perf_dropped_o = perf_dropped_q;
`endif

endmodule
